// File: rtl/dec_n_scan_pkg.sv
// Shared types and defaults for the dec_n_scan decoder/scanner.
package dec_n_scan_pkg;

  localparam int unsigned DefN       = 3;
  localparam int unsigned DefScanDiv = 4;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StScan  = 2'd2
  } state_e;

endpackage

// File: rtl/dec_n_scan_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable.
module dec_n_scan_onehot #(
  parameter int unsigned N = 3
) (
  input  logic            en_i,
  input  logic [N-1:0]    sel_i,
  output logic [2**N-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/dec_n_scan.sv
// One-hot decoder with a single-entry valid/ready output stage, plus a free-running scan mode.
module dec_n_scan
  import dec_n_scan_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned ScanDiv = DefScanDiv
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mode_i,
  input  logic            en_i,
  input  logic [N-1:0]    w_i,
  input  logic            w_vld_i,
  output logic            w_rdy_o,
  input  logic [2**N-1:0] fmask_i,
  output logic [2**N-1:0] y_o,
  output logic            f_o,
  output logic            y_vld_o,
  input  logic            y_rdy_i,
  output logic [N-1:0]    idx_o,
  output logic            scan_tick_o
);

  localparam int unsigned Outs = 2**N;
  localparam int unsigned DivW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;

  state_e          st_q;
  logic [DivW-1:0] div_q;
  logic [N-1:0]    idx_q, idx_d;
  logic [Outs-1:0] y_q, dec_y;
  logic            f_q, y_vld_q, scan_tick_q;
  logic [N-1:0]    dec_sel;
  logic            dec_f, xfer, tc, step;

  always_comb begin
    // Ready is withheld in the scan->decode transition cycle so no handshake is lost.
    w_rdy_o = ~mode_i & (st_q != StScan) & (~y_vld_q | y_rdy_i);
    xfer    = w_vld_i & w_rdy_o;
    tc      = (div_q == DivW'(ScanDiv - 1));
    step    = (st_q == StScan) & mode_i & en_i & tc;
    idx_d   = idx_q;
    if (mode_i && st_q != StScan) idx_d = '0;
    else if (step)                idx_d = idx_q + N'(1);
    dec_sel = mode_i ? idx_d : w_i;
    dec_f   = en_i & fmask_i[dec_sel];
  end

  dec_n_scan_onehot #(
    .N(N)
  ) u_onehot (
    .en_i (en_i),
    .sel_i(dec_sel),
    .y_o  (dec_y)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q        <= StEmpty;
      div_q       <= '0;
      idx_q       <= '0;
      y_q         <= '0;
      f_q         <= 1'b0;
      y_vld_q     <= 1'b0;
      scan_tick_q <= 1'b0;
    end else begin
      scan_tick_q <= 1'b0;
      if (mode_i) begin
        if (st_q != StScan) begin
          st_q    <= StScan;
          div_q   <= '0;
          idx_q   <= '0;
          y_q     <= dec_y;
          f_q     <= dec_f;
          y_vld_q <= 1'b0;
        end else if (en_i) begin
          div_q       <= tc ? '0 : div_q + DivW'(1);
          idx_q       <= idx_d;
          y_q         <= dec_y;
          f_q         <= dec_f;
          scan_tick_q <= tc;
        end else begin
          y_q <= '0;
          f_q <= 1'b0;
        end
      end else if (st_q == StScan) begin
        st_q    <= StEmpty;
        y_q     <= '0;
        f_q     <= 1'b0;
        y_vld_q <= 1'b0;
      end else if (xfer) begin
        st_q    <= StFull;
        y_q     <= dec_y;
        f_q     <= dec_f;
        y_vld_q <= 1'b1;
      end else if (y_vld_q && y_rdy_i) begin
        st_q    <= StEmpty;
        y_vld_q <= 1'b0;
      end
    end
  end

  assign y_o         = y_q;
  assign f_o         = f_q;
  assign y_vld_o     = y_vld_q;
  assign idx_o       = idx_q;
  assign scan_tick_o = scan_tick_q;

endmodule

// File: tb/tb_dec_n_scan.sv
// Directed-vector bench for dec_n_scan (N=3, ScanDiv=4, fmask=8'hE8).
module tb_dec_n_scan;

  logic       clk = 1'b0;
  logic       rst_n, mode, en, w_vld, w_rdy, y_rdy, f, y_vld, scan_tick;
  logic [2:0] w, idx;
  logic [7:0] fmask, y;

  int vecs = 0;
  int errs = 0;

  // Reference scan position kept by the bench.
  logic [2:0] exp_idx;
  int         exp_div;
  logic       exp_tick;
  int         ticks;

  dec_n_scan #(
    .N(3),
    .ScanDiv(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (mode),
    .en_i       (en),
    .w_i        (w),
    .w_vld_i    (w_vld),
    .w_rdy_o    (w_rdy),
    .fmask_i    (fmask),
    .y_o        (y),
    .f_o        (f),
    .y_vld_o    (y_vld),
    .y_rdy_i    (y_rdy),
    .idx_o      (idx),
    .scan_tick_o(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; en = 1'b1; w = '0; w_vld = 1'b0; y_rdy = 1'b0; fmask = 8'hE8;
    @(negedge clk);
    @(negedge clk);
    vecs++; if (y !== 8'h00) begin errs++; $display("FAIL reset_y got %h want 00", y); end
    vecs++; if (f !== 1'b0) begin errs++; $display("FAIL reset_f got %b want 0", f); end
    vecs++; if (y_vld !== 1'b0) begin errs++; $display("FAIL reset_yvld got %b want 0", y_vld); end
    vecs++; if (idx !== 3'd0) begin errs++; $display("FAIL reset_idx got %0d want 0", idx); end
    vecs++; if (w_rdy !== 1'b1) begin errs++; $display("FAIL reset_wrdy got %b want 1", w_rdy); end
    vecs++; if (scan_tick !== 1'b0) begin errs++; $display("FAIL reset_tick got %b want 0", scan_tick); end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    w = 3'd5; w_vld = 1'b1; y_rdy = 1'b1;
    #1;
    vecs++; if (w_rdy !== 1'b1) begin errs++; $display("FAIL dec_wrdy got %b want 1", w_rdy); end
    @(negedge clk);
    vecs++; if (y !== 8'h20) begin errs++; $display("FAIL dec5_y got %h want 20", y); end
    vecs++; if (f !== 1'b1) begin errs++; $display("FAIL dec5_f got %b want 1", f); end
    vecs++; if (y_vld !== 1'b1) begin errs++; $display("FAIL dec5_yvld got %b want 1", y_vld); end
    w = 3'd2;
    @(negedge clk);
    vecs++; if (y !== 8'h04) begin errs++; $display("FAIL dec2_y got %h want 04", y); end
    vecs++; if (f !== 1'b0) begin errs++; $display("FAIL dec2_f got %b want 0", f); end
    vecs++; if (y_vld !== 1'b1) begin errs++; $display("FAIL dec2_yvld got %b want 1", y_vld); end
  endtask

  task automatic test_back_to_back();
    w = 3'd5;
    @(negedge clk);
    vecs++; if (y !== 8'h20) begin errs++; $display("FAIL bp_load_y got %h want 20", y); end
    y_rdy = 1'b0; w = 3'd1;
    #1;
    vecs++; if (w_rdy !== 1'b0) begin errs++; $display("FAIL bp_wrdy got %b want 0", w_rdy); end
    @(negedge clk);
    vecs++; if (y !== 8'h20) begin errs++; $display("FAIL bp_hold_y got %h want 20", y); end
    vecs++; if (y_vld !== 1'b1) begin errs++; $display("FAIL bp_hold_yvld got %b want 1", y_vld); end
    y_rdy = 1'b1;
    @(negedge clk);
    vecs++; if (y !== 8'h02) begin errs++; $display("FAIL bp_next_y got %h want 02", y); end
    vecs++; if (y_vld !== 1'b1) begin errs++; $display("FAIL bp_next_yvld got %b want 1", y_vld); end
  endtask

  task automatic test_drain_and_disable();
    w = 3'd6;
    @(negedge clk);
    vecs++; if (y !== 8'h40 || f !== 1'b1) begin
      errs++; $display("FAIL w6 got y=%h f=%b want y=40 f=1", y, f);
    end
    w_vld = 1'b0;
    @(negedge clk);
    vecs++; if (y_vld !== 1'b0) begin errs++; $display("FAIL drain_yvld got %b want 0", y_vld); end
    vecs++; if (y !== 8'h40 || f !== 1'b1) begin
      errs++; $display("FAIL drain_hold got y=%h f=%b want y=40 f=1", y, f);
    end
    en = 1'b0; w = 3'd7; w_vld = 1'b1;
    @(negedge clk);
    vecs++; if (y !== 8'h00 || f !== 1'b0 || y_vld !== 1'b1) begin
      errs++; $display("FAIL en0 got y=%h f=%b vld=%b want y=00 f=0 vld=1", y, f, y_vld);
    end
    w_vld = 1'b0;
    @(negedge clk);
    vecs++; if (y_vld !== 1'b0) begin errs++; $display("FAIL en0_drain got %b want 0", y_vld); end
    en = 1'b1;
  endtask

  task automatic scan_cycle(input string tag);
    @(negedge clk);
    if (en) begin
      if (exp_div == 3) begin exp_div = 0; exp_idx = exp_idx + 3'd1; exp_tick = 1'b1; end
      else begin exp_div++; exp_tick = 1'b0; end
    end else begin
      exp_tick = 1'b0;
    end
    vecs++;
    if (idx !== exp_idx || scan_tick !== exp_tick || y_vld !== 1'b0 ||
        y !== (en ? (8'h01 << exp_idx) : 8'h00) || f !== (en & fmask[exp_idx])) begin
      errs++;
      $display("FAIL %s got idx=%0d tick=%b y=%h f=%b vld=%b want idx=%0d tick=%b y=%h f=%b vld=0",
               tag, idx, scan_tick, y, f, y_vld, exp_idx, exp_tick,
               en ? (8'h01 << exp_idx) : 8'h00, en & fmask[exp_idx]);
    end
    if (scan_tick === 1'b1) ticks++;
  endtask

  task automatic test_scan();
    mode = 1'b1; en = 1'b1; w_vld = 1'b0;
    @(negedge clk);
    exp_idx = 3'd0; exp_div = 0; exp_tick = 1'b0; ticks = 0;
    vecs++; if (y !== 8'h01 || idx !== 3'd0 || scan_tick !== 1'b0 || w_rdy !== 1'b0) begin
      errs++; $display("FAIL scan_entry got y=%h idx=%0d tick=%b wrdy=%b want 01 0 0 0",
                       y, idx, scan_tick, w_rdy);
    end
    for (int c = 0; c < 36; c++) scan_cycle("scan_run");
    vecs++; if (ticks != 9) begin errs++; $display("FAIL scan_ticks got %0d want 9", ticks); end
    for (int c = 0; c < 12 && !(exp_idx == 3'd2 && exp_tick); c++) scan_cycle("scan_to2");
    en = 1'b0;
    for (int c = 0; c < 3; c++) scan_cycle("scan_frozen");
    vecs++; if (idx !== 3'd2 || y !== 8'h00) begin
      errs++; $display("FAIL freeze got idx=%0d y=%h want 2 00", idx, y);
    end
    en = 1'b1;
    scan_cycle("scan_resume");
    vecs++; if (y !== 8'h04) begin errs++; $display("FAIL resume_y got %h want 04", y); end
  endtask

  task automatic test_scan_reset();
    for (int c = 0; c < 20 && exp_idx != 3'd5; c++) scan_cycle("scan_to5");
    vecs++; if (idx !== 3'd5) begin errs++; $display("FAIL pre_rst_idx got %0d want 5", idx); end
    rst_n = 1'b0;
    @(negedge clk);
    vecs++; if (y !== 8'h00 || idx !== 3'd0 || scan_tick !== 1'b0 || f !== 1'b0) begin
      errs++; $display("FAIL scan_rst got y=%h idx=%0d tick=%b f=%b want 00 0 0 0",
                       y, idx, scan_tick, f);
    end
    rst_n = 1'b1; mode = 1'b0;
    #1;
    vecs++; if (w_rdy !== 1'b1) begin errs++; $display("FAIL post_rst_wrdy got %b want 1", w_rdy); end
    @(negedge clk);
    vecs++; if (y !== 8'h00 || y_vld !== 1'b0) begin
      errs++; $display("FAIL post_rst_idle got y=%h vld=%b want 00 0", y, y_vld);
    end
  endtask

  task automatic test_mode_switch();
    y_rdy = 1'b0; w = 3'd3; w_vld = 1'b1;
    @(negedge clk);
    vecs++; if (y !== 8'h08 || f !== 1'b1 || y_vld !== 1'b1) begin
      errs++; $display("FAIL pend got y=%h f=%b vld=%b want 08 1 1", y, f, y_vld);
    end
    w_vld = 1'b0; mode = 1'b1;
    @(negedge clk);
    vecs++; if (y_vld !== 1'b0 || y !== 8'h01 || idx !== 3'd0) begin
      errs++; $display("FAIL discard got vld=%b y=%h idx=%0d want 0 01 0", y_vld, y, idx);
    end
    @(negedge clk);
    mode = 1'b0;
    @(negedge clk);
    vecs++; if (y !== 8'h00 || f !== 1'b0 || y_vld !== 1'b0) begin
      errs++; $display("FAIL exit got y=%h f=%b vld=%b want 00 0 0", y, f, y_vld);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_drain_and_disable();
    test_scan();
    test_scan_reset();
    test_mode_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
